// File: rtl/GEMM_pkg.sv
// Shared types and helpers for the GEMM systolic-array datapath.
// sat_add is used by sa_output_accumulator when ACC_SATURATE_EN is defined.
package GEMM_pkg;

    localparam int ACC_SIZE_DEFAULT = 32;
    typedef logic [ACC_SIZE_DEFAULT-1:0] acc_t;

    // Wide enough to hold any accumulator sum without losing the carry.
    localparam int SAT_WIDE = 64;
    typedef logic [SAT_WIDE-1:0] wide_t;

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int width);
        wide_t sum;
        wide_t max_val;
        sum     = a + b;
        max_val = (wide_t'(1) << width) - wide_t'(1);
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage

// File: rtl/sa_output_accumulator_if.sv
// Input-vector and result-FIFO handshake bundle for sa_output_accumulator.
// The accumulator is the slave side; the array and consumer are the master side.
interface sa_output_accumulator_if #(
    parameter int SA_SIZE                = 8,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int ACC_SIZE               = 32
);
    logic                                            in_valid;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] in_data;
    logic                                            out_valid;
    logic                                            out_ready;
    logic [SA_SIZE-1:0][ACC_SIZE-1:0]                out_data;
    logic                                            out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/sa_output_accumulator_fifo.sv
// sa_result_fifo: result FIFO with extra-bit wrap pointers; a push into a full
// FIFO is accepted only when the head is popped in the same cycle.
module sa_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !empty && pop_ready;
    assign accept     = push && (!full || pop);
    assign dropped    = push && !accept;
    assign head_valid = !empty;
    // Gated so the output reads zero out of reset and whenever nothing is queued.
    assign head_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/sa_output_accumulator.sv
// Accumulates systolic-array output rows over K-tiles and queues finished rows.
// Define ACC_SATURATE_EN to clamp accumulators instead of wrapping modulo 2^ACC_SIZE.
module sa_output_accumulator
    import GEMM_pkg::*;
#(
    parameter int SA_SIZE                = 8,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int ACC_SIZE               = ACC_SIZE_DEFAULT,
    parameter int ROWS                   = 4,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [7:0]            cfg_num_tiles,
    sa_output_accumulator_if.slave bus,
    output logic                  overflow,
    output logic                  busy
);
    localparam int              RIW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RIW-1:0]  LAST_ROW = RIW'(ROWS - 1);
    localparam int              ENTRY_W  = SA_SIZE * ACC_SIZE + 1;

    logic [RIW-1:0]                                  row_idx;
    logic [7:0]                                      tile_idx;
    logic [7:0]                                      num_tiles_q;
    logic [ACC_SIZE-1:0]                             acc [ROWS][SA_SIZE];
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] in_vec;
    logic [SA_SIZE-1:0][ACC_SIZE-1:0]                sum_row;
    logic                                            beat;
    logic                                            first_beat;
    logic [7:0]                                      cfg_eff;
    logic [7:0]                                      tiles_now;
    logic                                            last_tile;
    logic                                            push;
    logic                                            dropped;
    logic [ENTRY_W-1:0]                              head;

    assign in_vec     = bus.in_data;
    assign beat       = bus.in_valid && !clear;
    assign first_beat = (row_idx == '0) && (tile_idx == 8'd0);
    assign cfg_eff    = (cfg_num_tiles == 8'd0) ? 8'd1 : cfg_num_tiles;
    // The tile count only takes effect at the first beat of a block.
    assign tiles_now  = first_beat ? cfg_eff : num_tiles_q;
    assign last_tile  = (tile_idx == tiles_now - 8'd1);
    assign push       = beat && last_tile;
    assign busy       = (row_idx != '0) || (tile_idx != 8'd0);

    always_comb begin
        sum_row = '0;
        for (int e = 0; e < SA_SIZE; e++) begin
            if (tile_idx == 8'd0) begin
                sum_row[e] = ACC_SIZE'(in_vec[e]);
            end else begin
`ifdef ACC_SATURATE_EN
                sum_row[e] = ACC_SIZE'(sat_add(wide_t'(acc[row_idx][e]), wide_t'(in_vec[e]), ACC_SIZE));
`else
                sum_row[e] = acc[row_idx][e] + ACC_SIZE'(in_vec[e]);
`endif
            end
        end
    end

    // Accumulator contents are never reset; the first-tile overwrite initialises them.
    always_ff @(posedge clk) begin
        if (beat) begin
            for (int e = 0; e < SA_SIZE; e++) begin
                acc[row_idx][e] <= sum_row[e];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_idx     <= '0;
            tile_idx    <= 8'd0;
            num_tiles_q <= 8'd1;
        end else if (clear) begin
            row_idx     <= '0;
            tile_idx    <= 8'd0;
            num_tiles_q <= 8'd1;
        end else if (bus.in_valid) begin
            if (first_beat) num_tiles_q <= cfg_eff;
            if (row_idx == LAST_ROW) begin
                row_idx  <= '0;
                tile_idx <= last_tile ? 8'd0 : tile_idx + 8'd1;
            end else begin
                row_idx <= row_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        overflow <= 1'b0;
        else if (clear)   overflow <= 1'b0;
        else if (dropped) overflow <= 1'b1;
    end

    sa_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push       (push),
        .push_data  ({row_idx == LAST_ROW, sum_row}),
        .pop_ready  (bus.out_ready),
        .head_valid (bus.out_valid),
        .head_data  (head),
        .dropped    (dropped)
    );

    assign bus.out_data = head[ENTRY_W-2:0];
    assign bus.out_last = head[ENTRY_W-1];
endmodule

// File: tb/tb_sa_output_accumulator.sv
// Bench for sa_output_accumulator: 16-bit and 8-bit accumulator builds run in lockstep
// against a beat-count reference model, directed scenarios followed by random traffic.
module tb_sa_output_accumulator;
    localparam int SA   = 2;
    localparam int W    = 8;
    localparam int ROWS = 2;
    localparam int FD   = 2;

    typedef logic [SA-1:0][W-1:0] vec_t;
    typedef struct {
        logic [31:0] d16;
        logic [15:0] d8;
        logic        last;
    } row_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [7:0] cfg;
    logic       ovf16, busy16, ovf8, busy8;
    int         checks = 0;
    int         failures = 0;

    row_t   exp_q[$];
    longint acc16 [ROWS][SA];
    longint acc8  [ROWS][SA];
    int     beat_n = 0;
    int     blk_tiles = 1;
    bit     m_ovf = 1'b0;

    sa_output_accumulator_if #(.SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .ACC_SIZE(16)) bus16 ();
    sa_output_accumulator_if #(.SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .ACC_SIZE(8))  bus8 ();

    assign bus8.in_valid  = bus16.in_valid;
    assign bus8.in_data   = bus16.in_data;
    assign bus8.out_ready = bus16.out_ready;

    always #5 clk = ~clk;

    sa_output_accumulator #(.SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .ACC_SIZE(16),
                            .ROWS(ROWS), .FIFO_DEPTH(FD)) dut16 (
        .clk(clk), .reset(reset), .clear(clear), .cfg_num_tiles(cfg),
        .bus(bus16), .overflow(ovf16), .busy(busy16));

    sa_output_accumulator #(.SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .ACC_SIZE(8),
                            .ROWS(ROWS), .FIFO_DEPTH(FD)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .cfg_num_tiles(cfg),
        .bus(bus8), .overflow(ovf8), .busy(busy8));

    function automatic vec_t vec(input logic [7:0] a, input logic [7:0] b);
        return {b, a};
    endfunction

    function automatic longint add_acc(input longint a, input longint b, input int width);
        longint mx;
        mx = (longint'(1) << width) - 1;
`ifdef ACC_SATURATE_EN
        return (a + b > mx) ? mx : a + b;
`else
        return (a + b) & mx;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: a block is ROWS*tiles beats; beat n is row n%ROWS of tile n/ROWS.
    task automatic model_edge(input bit v, input vec_t d, input bit rdy, input bit clr);
        bit   popped;
        bit   do_push;
        int   row;
        int   tile;
        row_t ent;
        if (clr) begin
            exp_q.delete();
            beat_n = 0;
            m_ovf  = 1'b0;
            return;
        end
        popped  = rdy && (exp_q.size() > 0);
        do_push = 1'b0;
        ent     = '{d16: '0, d8: '0, last: 1'b0};
        if (v) begin
            if (beat_n == 0) blk_tiles = (cfg == 8'd0) ? 1 : int'(cfg);
            row  = beat_n % ROWS;
            tile = beat_n / ROWS;
            for (int e = 0; e < SA; e++) begin
                if (tile == 0) begin
                    acc16[row][e] = longint'(d[e]);
                    acc8[row][e]  = longint'(d[e]);
                end else begin
                    acc16[row][e] = add_acc(acc16[row][e], longint'(d[e]), 16);
                    acc8[row][e]  = add_acc(acc8[row][e], longint'(d[e]), 8);
                end
                ent.d16[e*16 +: 16] = 16'(acc16[row][e]);
                ent.d8[e*8 +: 8]    = 8'(acc8[row][e]);
            end
            ent.last = (row == ROWS - 1);
            if (tile == blk_tiles - 1) begin
                if (exp_q.size() < FD || popped) do_push = 1'b1;
                else m_ovf = 1'b1;
            end
            beat_n = (beat_n + 1) % (ROWS * blk_tiles);
        end
        if (popped)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(ent);
    endtask

    task automatic check_output();
        check("valid16", 64'(bus16.out_valid), 64'(exp_q.size() > 0));
        check("valid8", 64'(bus8.out_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("data16", 64'(bus16.out_data), 64'(exp_q[0].d16));
            check("data8", 64'(bus8.out_data), 64'(exp_q[0].d8));
            check("last16", 64'(bus16.out_last), 64'(exp_q[0].last));
            check("last8", 64'(bus8.out_last), 64'(exp_q[0].last));
        end
        check("overflow16", 64'(ovf16), 64'(m_ovf));
        check("overflow8", 64'(ovf8), 64'(m_ovf));
        check("busy16", 64'(busy16), 64'(beat_n != 0));
        check("busy8", 64'(busy8), 64'(beat_n != 0));
    endtask

    task automatic apply_stimulus(input bit v, input vec_t d, input bit rdy, input bit clr);
        bus16.in_valid  = v;
        bus16.in_data   = d;
        bus16.out_ready = rdy;
        clear           = clr;
        @(posedge clk);
        model_edge(v, d, rdy, clr);
        #1;
        check_output();
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        clear          = 1'b0;
        bus16.in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        beat_n = 0;
        m_ovf  = 1'b0;
        check("rst_valid", 64'(bus16.out_valid), 64'd0);
        check("rst_data16", 64'(bus16.out_data), 64'd0);
        check("rst_data8", 64'(bus8.out_data), 64'd0);
        check("rst_last", 64'(bus16.out_last), 64'd0);
        check("rst_overflow", 64'(ovf16), 64'd0);
        check("rst_busy", 64'(busy16), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] sat8;
        reset           = 1'b1;
        clear           = 1'b0;
        cfg             = 8'd1;
        bus16.in_valid  = 1'b0;
        bus16.in_data   = '0;
        bus16.out_ready = 1'b0;
        apply_reset();

        // Pass-through, one tile per block
        cfg = 8'd1;
        apply_stimulus(1, vec(6, 10), 1, 0);
        check("pass_row0", 64'(bus16.out_data), 64'({16'd10, 16'd6}));
        check("pass_last0", 64'(bus16.out_last), 64'd0);
        apply_stimulus(1, vec(9, 4), 1, 0);
        check("pass_row1", 64'(bus16.out_data), 64'({16'd4, 16'd9}));
        check("pass_last1", 64'(bus16.out_last), 64'd1);
        apply_stimulus(0, vec(0, 0), 1, 0);
        apply_reset();

        // Three-tile accumulation
        cfg = 8'd3;
        for (int t = 0; t < 3; t++) begin
            apply_stimulus(1, vec(1, 2), 1, 0);
            apply_stimulus(1, vec(3, 4), 1, 0);
        end
        check("acc_row1", 64'(bus16.out_data), 64'({16'd12, 16'd9}));
        check("acc_last", 64'(bus16.out_last), 64'd1);
        apply_reset();

        // Saturation versus wrap in the 8-bit build
        cfg = 8'd2;
        apply_stimulus(1, vec(200, 1), 1, 0);
        apply_stimulus(1, vec(200, 1), 1, 0);
        apply_stimulus(1, vec(200, 1), 1, 0);
`ifdef ACC_SATURATE_EN
        sat8 = 8'd255;
`else
        sat8 = 8'd144;
`endif
        check("sat_row8", 64'(bus8.out_data), 64'({8'd2, sat8}));
        check("sat_row16", 64'(bus16.out_data), 64'({16'd2, 16'd400}));
        apply_stimulus(1, vec(200, 1), 1, 0);
        apply_stimulus(0, vec(0, 0), 1, 0);
        apply_reset();

        // Backpressure: third row is dropped, first two drain in order
        cfg = 8'd1;
        apply_stimulus(1, vec(1, 2), 0, 0);
        apply_stimulus(1, vec(3, 4), 0, 0);
        apply_stimulus(1, vec(5, 6), 0, 0);
        check("bp_overflow", 64'(ovf16), 64'd1);
        check("bp_head", 64'(bus16.out_data), 64'({16'd2, 16'd1}));
        apply_stimulus(0, vec(0, 0), 0, 0);
        apply_stimulus(0, vec(0, 0), 1, 0);
        check("bp_second", 64'(bus16.out_data), 64'({16'd4, 16'd3}));
        apply_stimulus(0, vec(0, 0), 1, 0);
        apply_reset();

        // Full FIFO with a pop on the push cycle
        apply_stimulus(1, vec(1, 1), 0, 0);
        apply_stimulus(1, vec(2, 2), 0, 0);
        apply_stimulus(1, vec(3, 3), 1, 0);
        check("fullpop_overflow", 64'(ovf16), 64'd0);
        apply_stimulus(0, vec(0, 0), 1, 0);
        apply_stimulus(0, vec(0, 0), 1, 0);
        apply_reset();

        // Reset mid-block
        cfg = 8'd2;
        for (int i = 0; i < 3; i++) apply_stimulus(1, vec(1, 1), 1, 0);
        apply_reset();
        for (int i = 0; i < 4; i++) apply_stimulus(1, vec(1, 1), 1, 0);
        check("rst_mid_row", 64'(bus16.out_data), 64'({16'd2, 16'd2}));
        check("rst_mid_last", 64'(bus16.out_last), 64'd1);
        apply_stimulus(0, vec(0, 0), 1, 0);

        // Clear mid-block, with a beat in the clear cycle that must be discarded
        for (int i = 0; i < 3; i++) apply_stimulus(1, vec(7, 7), 1, 0);
        apply_stimulus(1, vec(9, 9), 1, 1);
        check("clr_busy", 64'(busy16), 64'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(1, vec(1, 1), 1, 0);
        check("clr_mid_row", 64'(bus16.out_data), 64'({16'd2, 16'd2}));
        apply_stimulus(0, vec(0, 0), 1, 0);

        // Random traffic with occasional reconfiguration, clear and reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) cfg = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) begin
                apply_reset();
            end else begin
                apply_stimulus($urandom_range(0, 3) != 0, vec(8'($urandom), 8'($urandom)),
                               $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
